game_stats: RTL

Score/time bookkeeping stage between the game cores (snake, tron) and the eight hex decoders. Tracks the current game's elapsed seconds (4 BCD digits), objects eaten (2 BCD digits) and session high score (2 BCD digits). Consumes single-cycle event pulses from the active game and presents registered 4-bit digits ready for `hex_decoder`.

---
 rtl/game_stats_pkg.sv | 20 ++
 rtl/game_stats_bcd_digit.sv | 40 ++++
 rtl/game_stats.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_stats_pkg.sv
// Shared definitions for the game_stats score/time bookkeeping stage:
// FSM encoding, BCD digit constants and a two-digit BCD compare helper.
package game_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Tens digit decides first; units only break a tie.
  function automatic logic bcd2_gt(input logic [BCD_W-1:0] a1, input logic [BCD_W-1:0] a0,
                                   input logic [BCD_W-1:0] b1, input logic [BCD_W-1:0] b0);
    return (a1 > b1) || ((a1 == b1) && (a0 > b0));
  endfunction

endpackage

// File: rtl/game_stats_bcd_digit.sv
// Single registered BCD digit with synchronous clear, increment enable,
// saturation hold and carry-out; cascaded to build multi-digit counters.
module bcd_digit
  import game_stats_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             hold,
  output logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] digit_next,
  output logic             carry
);

  logic [BCD_W-1:0] digit_reg;

  // Carry ignores hold so a saturation detector can be built from it without a loop.
  assign carry = inc && (digit_reg == BCD_MAX);

  always_comb begin
    digit_next = digit_reg;
    if (clr) begin
      digit_next = '0;
    end else if (inc && !hold) begin
      digit_next = (digit_reg == BCD_MAX) ? '0 : digit_reg + BCD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit = digit_reg;

endmodule

// File: rtl/game_stats.sv
// Game score/time bookkeeping: elapsed seconds (4 BCD), eaten count (2 BCD)
// and session high score (2 BCD, present only when GAME_STATS_HISCORE_EN is defined).
module game_stats
  import game_stats_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             eat,
  input  logic             game_over,
  output logic             running,
  output logic [BCD_W-1:0] time_d3,
  output logic [BCD_W-1:0] time_d2,
  output logic [BCD_W-1:0] time_d1,
  output logic [BCD_W-1:0] time_d0,
  output logic [BCD_W-1:0] score_d1,
  output logic [BCD_W-1:0] score_d0,
  output logic [BCD_W-1:0] hiscore_d1,
  output logic [BCD_W-1:0] hiscore_d0
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_reg;
  logic             running_reg;
  logic [PRE_W-1:0] pre_reg;

  logic in_run;
  logic enter_run;
  logic tick;
  logic eat_run;
  logic end_game;

  assign in_run    = (state_reg == ST_RUNNING);
  assign enter_run = start && !in_run;
  assign tick      = in_run && (pre_reg == PRE_LAST);
  assign eat_run   = in_run && eat;
  assign end_game  = in_run && game_over;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      running_reg <= 1'b0;
      pre_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_reg   <= ST_RUNNING;
            running_reg <= 1'b1;
            pre_reg     <= '0;
          end
        end
        ST_RUNNING: begin
          pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
          if (game_over) begin
            state_reg   <= ST_OVER;
            running_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign running = running_reg;

  // Elapsed time: ripple chain driven by the prescaler tick; 9999 wraps naturally.
  logic             time_chain [5];
  logic [BCD_W-1:0] time_digit [4];
  logic [BCD_W-1:0] time_next_unused [4];
  logic             time_wrap_unused;

  assign time_chain[0]  = tick;
  assign time_wrap_unused = time_chain[4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_time
      bcd_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .clr        (enter_run),
        .inc        (time_chain[gi]),
        .hold       (1'b0),
        .digit      (time_digit[gi]),
        .digit_next (time_next_unused[gi]),
        .carry      (time_chain[gi+1])
      );
    end
  endgenerate

  assign time_d0 = time_digit[0];
  assign time_d1 = time_digit[1];
  assign time_d2 = time_digit[2];
  assign time_d3 = time_digit[3];

  // Score: a carry out of the tens digit means 99 is already reached, so hold.
  logic             score_chain [3];
  logic [BCD_W-1:0] score_digit [2];
  logic [BCD_W-1:0] score_next  [2];
  logic             score_sat;

  assign score_chain[0] = eat_run;
  assign score_sat      = score_chain[2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_score
      bcd_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .clr        (enter_run),
        .inc        (score_chain[gi]),
        .hold       (score_sat),
        .digit      (score_digit[gi]),
        .digit_next (score_next[gi]),
        .carry      (score_chain[gi+1])
      );
    end
  endgenerate

  assign score_d0 = score_digit[0];
  assign score_d1 = score_digit[1];

`ifdef GAME_STATS_HISCORE_EN
  logic [BCD_W-1:0] hi1_reg;
  logic [BCD_W-1:0] hi0_reg;

  // Compare against the post-eat score so a same-cycle eat counts toward the record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi1_reg <= '0;
      hi0_reg <= '0;
    end else if (end_game && bcd2_gt(score_next[1], score_next[0], hi1_reg, hi0_reg)) begin
      hi1_reg <= score_next[1];
      hi0_reg <= score_next[0];
    end
  end

  assign hiscore_d1 = hi1_reg;
  assign hiscore_d0 = hi0_reg;
`else
  logic [2*BCD_W-1:0] hiscore_unused;
  logic               end_game_unused;

  assign hiscore_unused  = {score_next[1], score_next[0]};
  assign end_game_unused = end_game;
  assign hiscore_d1      = '0;
  assign hiscore_d0      = '0;
`endif

endmodule
